// File: rtl/rndgen_lfsr.sv
// rndgen_lfsr: parametrised XNOR LFSR random source with a valid/ready word output.
// The register is stepped OUT_W times per accepted word (unrolled chain), supports
// run-time seed load and keeps out of the all-ones lockup state.
// Optional feature: define RNDGEN_WRAP_DET_EN to add the period_wrap output, which pulses
// when the sequence returns to the state captured at reset or seed load.

package rndgen_pkg;

   // TapeNum = register length N; FB[] = 1-based tap positions, 0 = unused slot.
   typedef struct packed {
      int unsigned      TapeNum;
      logic [3:0][31:0] FB;
   } RndGenParams_t;

   localparam RndGenParams_t RndGen8  = '{TapeNum: 8,  FB: '{32'd8,  32'd6,  32'd5, 32'd4}};
   localparam RndGenParams_t RndGen16 = '{TapeNum: 16, FB: '{32'd16, 32'd15, 32'd13, 32'd4}};
   localparam RndGenParams_t RndGen31 = '{TapeNum: 31, FB: '{32'd31, 32'd28, 32'd0, 32'd0}};

endpackage

module rndgen_lfsr #(
   parameter rndgen_pkg::RndGenParams_t   PARAMS       = rndgen_pkg::RndGen31,
   parameter int unsigned                 OUT_W        = 8,
   parameter logic [PARAMS.TapeNum-1:0]   DEFAULT_SEED = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      seed_load,
   input  logic [PARAMS.TapeNum-1:0] seed,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_W-1:0]          out_data
`ifdef RNDGEN_WRAP_DET_EN
   ,
   output logic                      period_wrap
`endif
);

   localparam int unsigned N = PARAMS.TapeNum;
   localparam logic [N-1:0] LOCKUP = {N{1'b1}};

   if (OUT_W < 1 || OUT_W > N) begin : gen_bad_out_w
      $error("rndgen_lfsr: OUT_W must lie in 1..N");
   end

   // One XNOR step; newest bit enters at bit 0.
   function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
      logic fb;
      fb = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (PARAMS.FB[k] == 32'(j + 1)) begin
               fb = fb ^ s[j];
            end
         end
      end
      return {s[N-2:0], ~fb};
   endfunction

   logic [N-1:0] s_q;
   logic [N-1:0] s_after;
   logic [N-1:0] s_adv;
   logic [N-1:0] load_val;
   logic         adv;

   // Unrolled OUT_W-step chain plus lockup guard and seed sanitising.
   always_comb begin
      s_after = s_q;
      for (int unsigned i = 0; i < OUT_W; i++) begin
         s_after = lfsr_step(s_after);
      end
      // Unreachable from a legal state; guards against upsets or a bad DEFAULT_SEED path.
      s_adv    = (s_after == LOCKUP) ? DEFAULT_SEED : s_after;
      load_val = (seed == LOCKUP) ? DEFAULT_SEED : seed;
      adv      = en & ~seed_load & (~out_valid | out_ready);
   end

   // State, output word and handshake flag; seed load discards any pending word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q       <= DEFAULT_SEED;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (seed_load) begin
         s_q       <= load_val;
         out_valid <= 1'b0;
      end else if (adv) begin
         s_q       <= s_adv;
         out_data  <= s_adv[OUT_W-1:0];
         out_valid <= 1'b1;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (s_q == LOCKUP) begin
            s_q <= DEFAULT_SEED;
         end
      end
   end

`ifdef RNDGEN_WRAP_DET_EN
   logic [N-1:0] ref_q;

   // Reference state captured at reset/load; pulse the cycle after a word lands on it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q       <= DEFAULT_SEED;
         period_wrap <= 1'b0;
      end else if (seed_load) begin
         ref_q       <= load_val;
         period_wrap <= 1'b0;
      end else if (adv) begin
         period_wrap <= (s_adv == ref_q);
      end else begin
         period_wrap <= 1'b0;
      end
   end
`else
   // Wrap detection disabled: no reference register, no period_wrap port.
`endif

endmodule

// File: tb/tb_rndgen_lfsr.sv
// tb_rndgen_lfsr: directed bench for rndgen_lfsr using RndGen8 with OUT_W=8 and OUT_W=1.
module tb_rndgen_lfsr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       en8, ld8, rdy8, v8;
   logic [7:0] seed8, d8;
   logic       en1, ld1, rdy1, v1;
   logic [7:0] seed1;
   logic [0:0] d1;
`ifdef RNDGEN_WRAP_DET_EN
   logic       wrap8, wrap1;
`endif

   rndgen_lfsr #(
      .PARAMS       (rndgen_pkg::RndGen8),
      .OUT_W        (8),
      .DEFAULT_SEED (8'h00)
   ) u_dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en8),
      .seed_load   (ld8),
      .seed        (seed8),
      .out_valid   (v8),
      .out_ready   (rdy8),
      .out_data    (d8)
`ifdef RNDGEN_WRAP_DET_EN
      ,
      .period_wrap (wrap8)
`endif
   );

   rndgen_lfsr #(
      .PARAMS       (rndgen_pkg::RndGen8),
      .OUT_W        (1),
      .DEFAULT_SEED (8'h00)
   ) u_dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en1),
      .seed_load   (ld1),
      .seed        (seed1),
      .out_valid   (v1),
      .out_ready   (rdy1),
      .out_data    (d1)
`ifdef RNDGEN_WRAP_DET_EN
      ,
      .period_wrap (wrap1)
`endif
   );

   // Hand-derived RndGen8 states from seed 0.
   localparam logic [7:0] S1 [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A, 8'hF4};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] st8(input logic [7:0] x);
      return {x[6:0], ~(x[7] ^ x[5] ^ x[4] ^ x[3])};
   endfunction

   function automatic logic [7:0] wd8(input logic [7:0] x);
      logic [7:0] y;
      y = x;
      for (int i = 0; i < 8; i++) y = st8(y);
      return y;
   endfunction

   logic [7:0] m8;
   logic [7:0] held;

   initial begin
      rst_n = 1'b0;
      en8 = 1'b0; ld8 = 1'b0; seed8 = 8'h00; rdy8 = 1'b1;
      en1 = 1'b0; ld1 = 1'b0; seed1 = 8'h00; rdy1 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_v8", 32'(v8), 32'd0);
      chk("rst_d8", 32'(d8), 32'd0);
      chk("rst_v1", 32'(v1), 32'd0);
      chk("rst_d1", 32'(d1), 32'd0);

      // Scenarios 1 and 2: free-running from reset.
      rst_n = 1'b1; en1 = 1'b1; en8 = 1'b1;
      m8 = 8'h00;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         m8 = wd8(m8);
         chk("s1_bit", 32'(d1), 32'(S1[i][0]));
         chk("s1_valid", 32'(v1), 32'd1);
         if (i == 0) chk("s2_first", 32'(d8), 32'hF4);
         else        chk("s2_word", 32'(d8), 32'(m8));
         chk("s2_valid", 32'(v8), 32'd1);
      end

      // Long run: stream continuity and (if enabled) wrap pulse every 255 one-bit words.
      for (int w = 9; w <= 510; w++) begin
         @(negedge clk);
         m8 = wd8(m8);
         chk("s2_stream", 32'(d8), 32'(m8));
`ifdef RNDGEN_WRAP_DET_EN
         chk("s6_wrap1", 32'(wrap1), 32'((w % 255) == 0));
`endif
      end

      // Scenario 3: back-pressure for 5 cycles.
      rdy8 = 1'b0;
      held = m8;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("s3_hold_data", 32'(d8), 32'(held));
         chk("s3_hold_valid", 32'(v8), 32'd1);
      end
      rdy8 = 1'b1;
      @(negedge clk);
      m8 = wd8(m8);
      chk("s3_resume1", 32'(d8), 32'(m8));
      @(negedge clk);
      m8 = wd8(m8);
      chk("s3_resume2", 32'(d8), 32'(m8));

      // en=0: held word stays until accepted, then valid drops.
      en8 = 1'b0; rdy8 = 1'b0;
      @(negedge clk);
      chk("en0_valid_held", 32'(v8), 32'd1);
      chk("en0_data_held", 32'(d8), 32'(m8));
      rdy8 = 1'b1;
      @(negedge clk);
      chk("en0_valid_drop", 32'(v8), 32'd0);
      @(negedge clk);
      chk("en0_valid_stay", 32'(v8), 32'd0);
      en8 = 1'b1;
      @(negedge clk);
      m8 = wd8(m8);
      chk("en1_resume", 32'(d8), 32'(m8));
      chk("en1_valid", 32'(v8), 32'd1);

      // Scenario 4: seed load (with en=1, out_ready=1, pending word discarded).
      ld8 = 1'b1; seed8 = 8'hFF;
      ld1 = 1'b1; seed1 = 8'hFF;
      @(negedge clk);
      chk("s4_ff_v8", 32'(v8), 32'd0);
      chk("s4_ff_v1", 32'(v1), 32'd0);
      ld8 = 1'b0; ld1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("s4_ff_word8", 32'(d8), 32'hF4);
            chk("s4_ff_valid8", 32'(v8), 32'd1);
         end
         chk("s4_ff_bit1", 32'(d1), 32'(S1[i][0]));
      end
      ld8 = 1'b1; seed8 = 8'h01;
      ld1 = 1'b1; seed1 = 8'h01;
      @(negedge clk);
      chk("s4_01_v8", 32'(v8), 32'd0);
      chk("s4_01_v1", 32'(v1), 32'd0);
      ld8 = 1'b0; ld1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("s4_01_word8", 32'(d8), 32'hE8);
         chk("s4_01_bit1", 32'(d1), 32'(S1[i + 1][0]));
      end

      // Scenario 5: asynchronous reset mid-stream.
      chk("s5_pre_valid", 32'(v8), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_rst_v8", 32'(v8), 32'd0);
      chk("s5_rst_d8", 32'(d8), 32'd0);
      chk("s5_rst_v1", 32'(v1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("s5_restart_d8", 32'(d8), 32'hF4);
      chk("s5_restart_v8", 32'(v8), 32'd1);
      chk("s5_restart_d1", 32'(d1), 32'(S1[0][0]));
      @(negedge clk);
      chk("s5_restart_d1b", 32'(d1), 32'(S1[1][0]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
